// File: rtl/key_expander_seq.sv
// Sequential AES key-schedule engine for 128/192/256-bit keys: one schedule word per clock
// into an internal word store, with a registered 128-bit round-key read port.
module key_expander_seq #(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [0:32*MAX_NK-1]  key,
    input  logic [3:0]            rk_idx,
    output logic [0:127]          rk,
    output logic [3:0]            nr,
    output logic                  busy,
    output logic                  done,
    output logic                  keys_valid,
    output logic                  err
);

    localparam int STORE_DEPTH = 4 * (MAX_NK + 7);
    localparam int IDX_W       = $clog2(STORE_DEPTH);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_mod;
    logic [7:0]       r_rcon;
    logic [3:0]       r_nk;
    logic [3:0]       r_nr;
    logic             r_done;
    logic             r_err;
    logic             r_keys_valid;
    logic [0:127]     r_rk;
    logic [31:0]      r_store [0:STORE_DEPTH-1];

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_reject;
    logic             w_len_ok;
    logic [3:0]       w_nk;
    logic [3:0]       w_nr;
    logic [IDX_W-1:0] w_last_idx;
    logic [IDX_W-1:0] w_prev_addr;
    logic [IDX_W-1:0] w_far_addr;
    logic [31:0]      w_prev;
    logic [31:0]      w_far;
    logic [31:0]      w_sub;
    logic [31:0]      w_temp;
    logic [31:0]      w_new;
    logic [7:0]       w_rcon_next;
    logic [3:0]       w_rk_sel;
    logic [IDX_W-1:0] w_rk_base;

    always_comb begin
        w_len_ok = 1'b1;
        w_nk     = 4'd4;
        w_nr     = 4'd10;
        case (key_len)
            2'b00:   begin w_nk = 4'd4; w_nr = 4'd10; end
            2'b01:   begin w_nk = 4'd6; w_nr = 4'd12; end
            2'b10:   begin w_nk = 4'd8; w_nr = 4'd14; end
            default: w_len_ok = 1'b0;
        endcase
    end

    assign w_last_idx = IDX_W'({r_nr, 2'b00}) + IDX_W'(3);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && w_len_ok) begin
                    w_load       = 1'b1;
                    w_state_next = ST_EXPAND;
                end else if (start) begin
                    w_reject = 1'b1;
                end
            end
            ST_EXPAND: begin
                w_step = 1'b1;
                if (r_idx == w_last_idx) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Single SubWord path: RotWord is applied in front of it only on the i mod Nk = 0 step.
    assign w_prev_addr = r_idx - IDX_W'(1);
    assign w_far_addr  = r_idx - IDX_W'(r_nk);
    assign w_prev      = r_store[w_prev_addr];
    assign w_far       = r_store[w_far_addr];
    assign w_sub       = sub_word((r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0) begin
            w_temp = w_sub ^ {r_rcon, 24'h0};
        end else if (r_nk == 4'd8 && r_mod == 3'd4) begin
            w_temp = w_sub;
        end
    end

    assign w_new = w_far ^ w_temp;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_mod        <= '0;
            r_rcon       <= 8'h01;
            r_nk         <= 4'd4;
            r_nr         <= 4'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
            r_err   <= w_reject;
            if (w_load) begin
                r_idx        <= IDX_W'(w_nk);
                r_mod        <= 3'd0;
                r_rcon       <= 8'h01;
                r_nk         <= w_nk;
                r_nr         <= w_nr;
                r_keys_valid <= 1'b0;
            end else if (w_step) begin
                r_idx <= r_idx + IDX_W'(1);
                r_mod <= (r_mod == 3'(r_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
                if (r_mod == 3'd0) begin
                    r_rcon <= w_rcon_next;
                end
                if (w_last) begin
                    r_keys_valid <= 1'b1;
                end
            end
        end
    end

    // NOTE: the word store has no reset; its contents are meaningless until keys_valid is set.
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (k < int'(w_nk)) begin
                    r_store[k] <= key[32*k +: 32];
                end
            end
        end else if (w_step) begin
            r_store[r_idx] <= w_new;
        end
    end

    assign w_rk_sel  = (rk_idx > r_nr) ? 4'd0 : rk_idx;
    assign w_rk_base = IDX_W'({w_rk_sel, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk <= '0;
        end else if (!r_keys_valid || rk_idx > r_nr) begin
            r_rk <= '0;
        end else begin
            r_rk <= {r_store[w_rk_base], r_store[w_rk_base + IDX_W'(1)],
                     r_store[w_rk_base + IDX_W'(2)], r_store[w_rk_base + IDX_W'(3)]};
        end
    end

    assign rk         = r_rk;
    assign nr         = r_nr;
    assign busy       = (r_state == ST_EXPAND);
    assign done       = r_done;
    assign keys_valid = r_keys_valid;
    assign err        = r_err;

endmodule

// File: tb/tb_key_expander_seq.sv
// Directed bench for key_expander_seq using the FIPS-197 key-expansion vectors.
module tb_key_expander_seq;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [1:0]     key_len;
    logic [0:255]   key;
    logic [3:0]     rk_idx;
    logic [0:127]   rk;
    logic [3:0]     nr;
    logic           busy;
    logic           done;
    logic           keys_valid;
    logic           err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [0:255] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_expander_seq #(.MAX_NK(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_len    (key_len),
        .key        (key),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .nr         (nr),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input logic [3:0] idx);
        rk_idx = idx;
        tick();
    endtask

    // Issues one start and counts edges until done; 100 means the run never finished.
    task automatic run_key(input logic [1:0] len, input logic [0:255] k, output int cycles);
        key_len = len;
        key     = k;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cycles;
        rst_n   = 1'b0;
        start   = 1'b0;
        key_len = 2'b00;
        key     = '0;
        rk_idx  = 4'd0;
        tick();
        tick();
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_valid", 128'(keys_valid), 128'd0);
        check("reset_nr", 128'(nr), 128'd0);
        check("reset_rk", rk, 128'd0);
        check("reset_err", 128'(err), 128'd0);
        rst_n = 1'b1;
        tick();

        // AES-128
        run_key(2'b00, KEY128, cycles);
        check("aes128_cycles", 128'(cycles), 128'd40);
        check("aes128_nr", 128'(nr), 128'd10);
        check("aes128_valid", 128'(keys_valid), 128'd1);
        check("aes128_busy_off", 128'(busy), 128'd0);
        tick();
        check("aes128_done_pulse", 128'(done), 128'd0);
        read_rk(4'd10);
        check("aes128_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4'd0);
        check("aes128_rk0", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_rk(4'd1);
        check("aes128_rk1", rk, 128'ha0fafe1788542cb123a339392a6c7605);

        // AES-192
        run_key(2'b01, KEY192, cycles);
        check("aes192_cycles", 128'(cycles), 128'd46);
        check("aes192_nr", 128'(nr), 128'd12);
        read_rk(4'd12);
        check("aes192_rk12", rk, 128'he98ba06f448c773c8ecc720401002202);
        read_rk(4'd0);
        check("aes192_rk0", rk, 128'h8e73b0f7da0e6452c810f32b809079e5);

        // AES-256
        run_key(2'b10, KEY256, cycles);
        check("aes256_cycles", 128'(cycles), 128'd52);
        check("aes256_nr", 128'(nr), 128'd14);
        read_rk(4'd14);
        check("aes256_rk14", rk, 128'hfe4890d1e6188d0b046df344706c631e);
        read_rk(4'd1);
        check("aes256_rk1", rk, 128'h1f352c073b6108d72d9810a30914dff4);
        read_rk(4'd15);
        check("aes256_rk15_zero", rk, 128'd0);

        // Illegal key length keeps the previous schedule.
        key_len = 2'b11;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("err_pulse", 128'(err), 128'd1);
        check("err_busy", 128'(busy), 128'd0);
        tick();
        check("err_one_cycle", 128'(err), 128'd0);
        check("err_busy_after", 128'(busy), 128'd0);
        check("err_valid_kept", 128'(keys_valid), 128'd1);
        check("err_nr_kept", 128'(nr), 128'd14);
        read_rk(4'd14);
        check("err_rk14_kept", rk, 128'hfe4890d1e6188d0b046df344706c631e);

        // Reset in the middle of an AES-256 run.
        key_len = 2'b10;
        key     = KEY256;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("mid_busy", 128'(busy), 128'd1);
        check("mid_valid_cleared", 128'(keys_valid), 128'd0);
        for (int c = 1; c < 20; c++) tick();
        rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(keys_valid), 128'd0);
        check("rst_rk", rk, 128'd0);
        check("rst_nr", 128'(nr), 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_key(2'b00, KEY128, cycles);
        check("post_rst_cycles", 128'(cycles), 128'd40);
        read_rk(4'd10);
        check("post_rst_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back runs: start wiggles mid-run, then is high on the done edge.
        key_len = 2'b00;
        key     = KEY128;
        start   = 1'b1;
        tick();
        cycles = 0;
        while (!done && cycles < 100) begin
            start = (cycles % 3 == 0);
            tick();
            cycles++;
        end
        check("b2b_first_cycles", 128'(cycles), 128'd40);
        start = 1'b1;
        tick();
        check("b2b_restart_busy", 128'(busy), 128'd1);
        check("b2b_restart_valid", 128'(keys_valid), 128'd0);
        cycles = 0;
        while (!done && cycles < 100) begin
            tick();
            cycles++;
        end
        start = 1'b0;
        check("b2b_second_cycles", 128'(cycles), 128'd40);
        tick();
        check("b2b_idle", 128'(busy), 128'd0);
        read_rk(4'd11);
        check("b2b_rk11_zero", rk, 128'd0);
        read_rk(4'd10);
        check("b2b_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
